// File: rtl/hash_request_front.sv
// Request front end for the XOR-hash table: buffers key/value/opcode requests, hashes the key
// to a table index and issues one request per cycle, stalling on in-flight write/delete hazards.
module hash_request_front #(
  parameter int unsigned          INDEX_WIDTH   = 12,
  parameter int unsigned          VALUE_WIDTH   = 31,
  parameter int unsigned          KEY_WIDTH     = 32,
  parameter int unsigned          FIFO_DEPTH    = 8,
  parameter logic [KEY_WIDTH-1:0] HASH_MULT     = 32'h9E3779B1,
  parameter int unsigned          HAZARD_WINDOW = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_opt,
  input  logic [KEY_WIDTH-1:0]          req_key,
  input  logic [VALUE_WIDTH-1:0]        req_value,
  output logic [INDEX_WIDTH-1:0]        index_out,
  output logic [KEY_WIDTH-1:0]          key_out,
  output logic [VALUE_WIDTH-1:0]        value_out,
  output logic [1:0]                    opt_out,
  output logic                          en_out,
  output logic                          hazard_stall,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [1:0]             opt;
    logic [VALUE_WIDTH-1:0] value;
    logic [KEY_WIDTH-1:0]   key;
  } req_t;

  // Request FIFO
  req_t            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;
  req_t            head;

  // Ready comes from registered occupancy only, so a pop never re-opens a full FIFO.
  assign req_ready  = (count_q != CntW'(FIFO_DEPTH));
  assign push       = req_valid && req_ready;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_opt, req_value, req_key};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Multiplicative hash: top INDEX_WIDTH bits of the truncated product
  logic [KEY_WIDTH-1:0]   hash_prod;
  logic [INDEX_WIDTH-1:0] head_index;

  assign hash_prod  = head.key * HASH_MULT;
  assign head_index = hash_prod[KEY_WIDTH-1 -: INDEX_WIDTH];

  // Hash stage register and hazard scoreboard
  logic                     h_valid_q, h_valid_d;
  req_t                     h_req_q, h_req_d;
  logic [INDEX_WIDTH-1:0]   h_index_q, h_index_d;
  logic [HAZARD_WINDOW-1:0] sb_valid_q, sb_valid_d;
  logic [INDEX_WIDTH-1:0]   sb_index_q [HAZARD_WINDOW];
  logic [INDEX_WIDTH-1:0]   sb_index_d [HAZARD_WINDOW];
  logic                     hit, issue, h_load;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < HAZARD_WINDOW; i++) begin
      if (sb_valid_q[i] && (sb_index_q[i] == h_index_q)) hit = 1'b1;
    end
  end

  assign issue        = h_valid_q && !hit;
  assign h_load       = !h_valid_q || issue;
  assign pop          = h_load && (count_q != '0);
  assign hazard_stall = h_valid_q && hit;

  always_comb begin
    h_valid_d = h_valid_q;
    h_req_d   = h_req_q;
    h_index_d = h_index_q;
    if (h_load) begin
      h_valid_d = pop;
      if (pop) begin
        h_req_d   = head;
        h_index_d = head_index;
      end
    end
  end

  // Reads are not tracked: they never modify the table, so they cannot create a hazard.
  always_comb begin
    sb_valid_d    = sb_valid_q;
    sb_valid_d[0] = issue && (h_req_q.opt != 2'b00);
    sb_index_d[0] = h_index_q;
    for (int i = 1; i < HAZARD_WINDOW; i++) begin
      sb_valid_d[i] = sb_valid_q[i-1];
      sb_index_d[i] = sb_index_q[i-1];
    end
  end

  // Output bus registers
  logic                   en_q, en_d;
  logic [INDEX_WIDTH-1:0] out_index_q, out_index_d;
  logic [KEY_WIDTH-1:0]   out_key_q, out_key_d;
  logic [VALUE_WIDTH-1:0] out_value_q, out_value_d;
  logic [1:0]             out_opt_q, out_opt_d;

  always_comb begin
    en_d        = issue;
    out_index_d = out_index_q;
    out_key_d   = out_key_q;
    out_value_d = out_value_q;
    out_opt_d   = out_opt_q;
    if (issue) begin
      out_index_d = h_index_q;
      out_key_d   = h_req_q.key;
      out_value_d = h_req_q.value;
      out_opt_d   = h_req_q.opt;
    end
  end

  assign en_out    = en_q;
  assign index_out = out_index_q;
  assign key_out   = out_key_q;
  assign value_out = out_value_q;
  assign opt_out   = out_opt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      h_valid_q   <= 1'b0;
      h_req_q     <= '0;
      h_index_q   <= '0;
      sb_valid_q  <= '0;
      for (int i = 0; i < HAZARD_WINDOW; i++) sb_index_q[i] <= '0;
      en_q        <= 1'b0;
      out_index_q <= '0;
      out_key_q   <= '0;
      out_value_q <= '0;
      out_opt_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      h_valid_q   <= h_valid_d;
      h_req_q     <= h_req_d;
      h_index_q   <= h_index_d;
      sb_valid_q  <= sb_valid_d;
      for (int i = 0; i < HAZARD_WINDOW; i++) sb_index_q[i] <= sb_index_d[i];
      en_q        <= en_d;
      out_index_q <= out_index_d;
      out_key_q   <= out_key_d;
      out_value_q <= out_value_d;
      out_opt_q   <= out_opt_d;
    end
  end

endmodule

// File: tb/tb_hash_request_front.sv
// Directed bench for hash_request_front: vector table for single issues plus hand-written
// hazard, streaming, full-FIFO, mid-stream reset and delete sequences.
module tb_hash_request_front;

  localparam int unsigned IW = 12;
  localparam int unsigned VW = 31;
  localparam int unsigned KW = 32;
  localparam int unsigned FD = 8;
  localparam int unsigned HW = 6;
  localparam int unsigned CW = $clog2(FD) + 1;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_opt;
  logic [KW-1:0] req_key;
  logic [VW-1:0] req_value;
  logic [IW-1:0] index_out;
  logic [KW-1:0] key_out;
  logic [VW-1:0] value_out;
  logic [1:0]    opt_out;
  logic          en_out;
  logic          hazard_stall;
  logic [CW-1:0] fifo_count;

  hash_request_front #(
    .INDEX_WIDTH  (IW),
    .VALUE_WIDTH  (VW),
    .KEY_WIDTH    (KW),
    .FIFO_DEPTH   (FD),
    .HASH_MULT    (32'h9E3779B1),
    .HAZARD_WINDOW(HW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opt     (req_opt),
    .req_key     (req_key),
    .req_value   (req_value),
    .index_out   (index_out),
    .key_out     (key_out),
    .value_out   (value_out),
    .opt_out     (opt_out),
    .en_out      (en_out),
    .hazard_stall(hazard_stall),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [KW-1:0] key;
    logic [VW-1:0] value;
    logic [1:0]    opt;
    logic [IW-1:0] idx;
  } vec_t;

  typedef struct {
    logic [IW-1:0] idx;
    logic [KW-1:0] key;
    logic [VW-1:0] value;
    logic [1:0]    opt;
    int            edge_no;
  } iss_t;

  iss_t          issued[$];
  int            edge_cnt = 0;
  int            stall_cycles = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [IW-1:0] idx_of [1:16];
  vec_t          vecs [5];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (en_out === 1'b1) issued.push_back('{index_out, key_out, value_out, opt_out, edge_cnt});
    if (hazard_stall === 1'b1) stall_cycles++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic iss_t get_iss(input int i);
    iss_t r;
    r.idx = '0; r.key = '0; r.value = '0; r.opt = '0; r.edge_no = -1000;
    if (i < issued.size()) r = issued[i];
    return r;
  endfunction

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [KW-1:0] k, input logic [VW-1:0] v, input logic [1:0] o,
                      output int acc_edge);
    int guard;
    guard     = 0;
    req_valid = 1'b1;
    req_key   = k;
    req_value = v;
    req_opt   = o;
    while (req_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: key=%0h actual=not accepted required=accepted", k);
    end
    acc_edge = edge_cnt + 1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_issues(input int n, input int budget, input string name);
    int t;
    t = 0;
    while (issued.size() < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (issued.size() < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: actual=%0d issues required=%0d", name, issued.size(), n);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int   a0, a1, base, s0;
    iss_t x, y;
    int   exp_keys [12];

    idx_of[1]  = 12'h9E3; idx_of[2]  = 12'h3C6; idx_of[3]  = 12'hDAA; idx_of[4]  = 12'h78D;
    idx_of[5]  = 12'h171; idx_of[6]  = 12'hB54; idx_of[7]  = 12'h538; idx_of[8]  = 12'hF1B;
    idx_of[9]  = 12'h8FF; idx_of[10] = 12'h2E2; idx_of[11] = 12'hCC6; idx_of[12] = 12'h6A9;
    idx_of[13] = 12'h08D; idx_of[14] = 12'hA70; idx_of[15] = 12'h454; idx_of[16] = 12'hE37;

    vecs[0] = '{32'd1,  31'd5,          2'b01, 12'h9E3};
    vecs[1] = '{32'd2,  31'd7,          2'b01, 12'h3C6};
    vecs[2] = '{32'd3,  31'h1234,       2'b00, 12'hDAA};
    vecs[3] = '{32'd4,  31'h7FFF_FFFF,  2'b10, 12'h78D};
    vecs[4] = '{32'd16, 31'h2A,         2'b11, 12'hE37};

    exp_keys = '{5, 5, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};

    req_valid = 1'b0; req_key = '0; req_value = '0; req_opt = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_en",     en_out,       0);
    check("rst_stall",  hazard_stall, 0);
    check("rst_count",  fifo_count,   0);
    check("rst_index",  index_out,    0);
    check("rst_key",    key_out,      0);
    check("rst_value",  value_out,    0);
    check("rst_opt",    opt_out,      0);
    idle(3);
    reset = 1'b1;
    check("rst_ready",  req_ready,    1);
    idle(2);

    // Single issues from the vector table, pipeline empty each time
    for (int i = 0; i < 5; i++) begin
      base = issued.size();
      send(vecs[i].key, vecs[i].value, vecs[i].opt, a0);
      wait_issues(base + 1, 20, "t1_issue");
      x = get_iss(base);
      check("t1_index",   x.idx,            vecs[i].idx);
      check("t1_key",     x.key,            vecs[i].key);
      check("t1_value",   x.value,          vecs[i].value);
      check("t1_opt",     x.opt,            vecs[i].opt);
      check("t1_latency", x.edge_no - a0,   2);
      idle(10);
      check("t1_single",  issued.size(),    base + 1);
    end

    // Write then read, same index: six bubbles
    base = issued.size(); s0 = stall_cycles;
    send(32'd1, 31'd11, 2'b01, a0);
    send(32'd1, 31'd0,  2'b00, a1);
    wait_issues(base + 2, 40, "t2_issue");
    x = get_iss(base); y = get_iss(base + 1);
    check("t2_gap",    y.edge_no - x.edge_no, 7);
    check("t2_stalls", stall_cycles - s0,     6);
    check("t2_opt0",   x.opt, 2'b01);
    check("t2_opt1",   y.opt, 2'b00);
    idle(10);

    // Read then read, same index: no stall
    base = issued.size(); s0 = stall_cycles;
    send(32'd1, 31'd0, 2'b00, a0);
    send(32'd1, 31'd0, 2'b00, a1);
    wait_issues(base + 2, 40, "t2r_issue");
    x = get_iss(base); y = get_iss(base + 1);
    check("t2r_gap",    y.edge_no - x.edge_no, 1);
    check("t2r_stalls", stall_cycles - s0,     0);
    idle(10);

    // Back-to-back stream, all indices distinct
    base = issued.size(); s0 = stall_cycles; a0 = 0;
    for (int k = 1; k <= 16; k++) begin
      send(KW'(k), VW'(k * 3), 2'b01, a1);
      if (k == 1) a0 = a1;
    end
    wait_issues(base + 16, 60, "t3_issue");
    x = get_iss(base);
    check("t3_latency", x.edge_no - a0, 2);
    for (int k = 0; k < 16; k++) begin
      y = get_iss(base + k);
      check("t3_index", y.idx,   idx_of[k + 1]);
      check("t3_key",   y.key,   k + 1);
      check("t3_value", y.value, (k + 1) * 3);
      if (k > 0) check("t3_gap", y.edge_no - x.edge_no, 1);
      x = y;
    end
    check("t3_stalls", stall_cycles - s0, 0);
    idle(10);

    // Full FIFO behind a hazard-blocked head
    base = issued.size();
    send(32'd5, 31'd101, 2'b01, a0);
    send(32'd5, 31'd102, 2'b01, a0);
    send(32'd5, 31'd103, 2'b01, a0);
    for (int k = 6; k <= 13; k++) send(KW'(k), VW'(100 + k), 2'b01, a1);
    check("t4_full_count", fifo_count, 8);
    check("t4_full_ready", req_ready,  0);
    req_valid = 1'b1; req_key = 32'd14; req_value = 31'd114; req_opt = 2'b01;
    idle(2);
    check("t4_hold_count", fifo_count, 8);
    check("t4_hold_ready", req_ready,  0);
    send(32'd14, 31'd114, 2'b01, a1);
    wait_issues(base + 12, 80, "t4_issue");
    idle(10);
    check("t4_total", issued.size(), base + 12);
    for (int k = 0; k < 12; k++) begin
      y = get_iss(base + k);
      check("t4_key",   y.key,   exp_keys[k]);
      check("t4_value", y.value, (k < 3) ? 101 + k : 100 + exp_keys[k]);
    end
    x = get_iss(base); y = get_iss(base + 1);
    check("t4_gap01", y.edge_no - x.edge_no, 7);
    x = get_iss(base + 2);
    check("t4_gap12", x.edge_no - y.edge_no, 7);

    // Reset mid-stream: five entries buffered, a stalled write in the hash stage
    send(32'd5, 31'd201, 2'b01, a0);
    send(32'd5, 31'd202, 2'b01, a0);
    for (int k = 6; k <= 10; k++) send(KW'(k), VW'(200 + k), 2'b01, a1);
    check("t5_pre_count", fifo_count,   5);
    check("t5_pre_stall", hazard_stall, 1);
    #2 reset = 1'b0;
    #1;
    check("t5_en",    en_out,       0);
    check("t5_index", index_out,    0);
    check("t5_key",   key_out,      0);
    check("t5_value", value_out,    0);
    check("t5_opt",   opt_out,      0);
    check("t5_count", fifo_count,   0);
    check("t5_stall", hazard_stall, 0);
    idle(2);
    reset = 1'b1;
    check("t5_ready", req_ready, 1);
    base = issued.size(); s0 = stall_cycles;
    send(32'd2, 31'd9, 2'b01, a0);
    wait_issues(base + 1, 20, "t5_issue");
    x = get_iss(base);
    check("t5_new_index",   x.idx,          12'h3C6);
    check("t5_new_key",     x.key,          2);
    check("t5_new_latency", x.edge_no - a0, 2);
    idle(10);
    check("t5_new_single",  issued.size(),  base + 1);
    check("t5_new_stalls",  stall_cycles - s0, 0);

    // Delete then write, same key
    base = issued.size(); s0 = stall_cycles;
    send(32'd1, 31'd0,  2'b11, a0);
    send(32'd1, 31'd33, 2'b01, a1);
    wait_issues(base + 2, 40, "t6_issue");
    x = get_iss(base); y = get_iss(base + 1);
    check("t6_gap",    y.edge_no - x.edge_no, 7);
    check("t6_stalls", stall_cycles - s0,     6);
    check("t6_opt0",   x.opt,   2'b11);
    check("t6_opt1",   y.opt,   2'b01);
    check("t6_value",  y.value, 33);
    idle(10);

    // Opcode 10 is tracked like a delete
    base = issued.size();
    send(32'd1, 31'd0, 2'b10, a0);
    send(32'd1, 31'd0, 2'b00, a1);
    wait_issues(base + 2, 40, "t6b_issue");
    x = get_iss(base); y = get_iss(base + 1);
    check("t6b_gap", y.edge_no - x.edge_no, 7);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hash_request_front.md
Name: hash_request_front

Overview:
- Front end of the XOR-hash table datapath. It sits directly upstream of the URAM write/XOR stage.
- Accepts key/value/opcode requests over a valid/ready handshake and buffers them in a FIFO.
- Computes the multiplicative-hash table index and issues one request per cycle on the index/key/value/opt/en bus the table stage consumes.
- Inserts bubbles so no request reaches an index that still has a write or delete in flight in the downstream pipeline.

Parameters:
- INDEX_WIDTH, 12, table index width.
- VALUE_WIDTH, 31, value width.
- KEY_WIDTH, 32, key width.
- FIFO_DEPTH, 8, request FIFO entries. Must be a power of 2, ≥2.
- HASH_MULT, 32'h9E3779B1, hash multiplier, KEY_WIDTH bits.
- HAZARD_WINDOW, 6, number of issued requests tracked. Equals the downstream write-back depth.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept this cycle.
- req_opt  in  2  opcode: 00 read, 01 write, 11 delete, 10 treated as delete.
- req_key  in  KEY_WIDTH  key.
- req_value  in  VALUE_WIDTH  value; ignored for read and delete but still carried.
- index_out  out  INDEX_WIDTH  hashed table index.
- key_out  out  KEY_WIDTH  key.
- value_out  out  VALUE_WIDTH  value.
- opt_out  out  2  opcode.
- en_out  out  1  one-cycle strobe; the request on the bus is valid this cycle.
- hazard_stall  out  1  high while the hash-stage request is blocked by a hazard.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO is emptied and the hash-stage valid bit is cleared.
  - All scoreboard entries are invalidated.
  - en_out=0, hazard_stall=0, fifo_count=0, and index_out, key_out, value_out, opt_out all reset to 0.
  - req_ready=1 in the first cycle after reset deasserts.
  - Reset mid-operation drops every buffered and in-flight request. No partial issue occurs.
- Handshake:
  - A request is accepted on an edge where req_valid && req_ready.
  - req_ready = (fifo_count != FIFO_DEPTH). It depends only on registered state; there is no combinational path from the pop.
  - When full, a same-cycle pop does not re-open req_ready.
  - Push and pop in the same cycle leave fifo_count unchanged.
- Hash stage (register H):
  - H loads the FIFO head when H is empty or H issues this cycle.
  - Loaded index = (head_key * HASH_MULT) mod 2^KEY_WIDTH, bits [KEY_WIDTH-1 -: INDEX_WIDTH].
- Scoreboard:
  - A HAZARD_WINDOW-entry shift register of {tracked, index}. Entry 0 corresponds to the output register.
  - Shifts every cycle. Entry 0 loads {issued && opt!=00, H.index}; a bubble loads tracked=0.
- Issue rule:
  - H issues if H is valid and no tracked entry has index == H.index.
  - Issuing loads the output registers with en_out=1. Otherwise en_out=0 and the other outputs hold their previous values.
  - hazard_stall = H valid && match.
  - Reads and writes are blocked alike. Ordering is strictly FIFO; there is no bypass or reordering.
- Latency:
  - With the pipeline empty and no hazard, a request accepted at edge E0 shows en_out=1 in the cycle after edge E2.
  - Sustained throughput is 1 request per cycle when all indices differ.
- Worst-case stall: HAZARD_WINDOW bubble cycles per conflicting pair. Back-to-back same-index requests issue exactly HAZARD_WINDOW+1 cycles apart.
- Read after read to the same index: no stall, because reads are not tracked.

Test Plan:
1. Reset, then single write: key=1, value=5, opt=01. -> en_out pulses once with index_out=0x9E3, key_out=1, value_out=5, opt_out=01, 2 edges after the accepting edge. Then key=2 -> index_out=0x3C6.
2. Hazard: write key=1, then read key=1 on the next cycle. -> Read en_out comes 7 cycles after the write en_out (6 bubbles), with hazard_stall=1 during the bubbles. Repeat with read then read -> en_out on consecutive cycles.
3. Back-to-back stream of keys 1..16, all indices distinct, req_valid held high. -> 16 consecutive en_out pulses in order and hazard_stall never asserts.
4. Full FIFO: block the head with a hazard and push until full. -> fifo_count=8, req_ready=0, the 9th request is not accepted, and no request is lost or duplicated once the stall clears.
5. Reset asserted mid-stream with the FIFO at 5 entries and a write in H. -> Outputs are 0 immediately (asynchronously) and fifo_count=0. After release, a new write key=2 issues with index 0x3C6 and no stale hazard stall.
6. Delete (opt=11) on key=1, then write key=1. -> Write is held 6 bubbles. opt_out for the two issues is 11 then 01.
